voice_scheduler: RTL
====================

Name: voice_scheduler

Overview:
- Sequences NUM_VOICES canon voices through one shared, registered note ROM, using a round-robin time-multiplexed ROM port.
- Produces per-voice divider values for the tone generators/sample block; divider 0 means the voice is silent.
- Owns the tempo tick, the per-voice start stagger, note durations, looping and start/stop control.

Parameters:
NUM_VOICES, 3, voices sharing the ROM port
IDX_W, 9, note index width
DIV_W, 11, divider width
STAGGER, 8, ticks of start delay per voice index (voice i waits STAGGER*i ticks)

Ports:
clk  in  1  project clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: (re)start all voices from index 0
stop  in  1  pulse: all voices to IDLE, silent
loop_en  in  1  1 = wrap at loop_end; 0 = stop at end
tempo_div  in  16  tick period minus 1, in clk cycles
loop_end  in  IDX_W  last note index
rom_addr  out  IDX_W  shared ROM address
rom_data  in  DIV_W+2  {dur[1:0], divider}; valid exactly 1 cycle after rom_addr
divider_o  out  NUM_VOICES*DIV_W  voice i occupies bits [i*DIV_W +: DIV_W]
note_strobe  out  NUM_VOICES  1-cycle pulse when voice i's note index changes
busy  out  1  any voice in WAIT or PLAY

Behaviour:
- Reset (async, rst_n=0): all outputs 0; all voices IDLE; note_idx=0; slot=0; tick counter=0; dur_q=0; hold counters 0.
- Tick generator:
  - tcnt counts 0..tempo_div, then wraps to 0.
  - tick is asserted in the cycle tcnt==tempo_div.
  - tempo_div=0 gives a tick every cycle.
  - Counts only while busy; held at 0 when not busy.
- Voice FSM, per voice i: IDLE, WAIT, PLAY, DONE.
  - IDLE/DONE/WAIT/PLAY --start--> WAIT with wcnt=STAGGER*i, note_idx=0, hold=0. If STAGGER*i==0, go directly to PLAY instead.
  - WAIT: wcnt decrements on each tick; when a tick arrives with wcnt==1, go to PLAY.
  - PLAY: on each tick, hold increments. When hold == (1<<dur_q[i])-1, the note ends: hold<=0.
    - If note_idx != loop_end: note_idx++.
    - Else if loop_en=1: note_idx<=0.
    - Else: go to DONE.
  - stop from any state -> IDLE. stop and start in the same cycle: stop wins.
  - start during PLAY restarts the voice; in that cycle the restart overrides any note end.
- note_strobe[i]:
  - Pulses in the cycle after note_idx[i] is written with a new value (advance or wrap).
  - Also pulses on entry to PLAY.
  - Does not pulse on stop or DONE.
- ROM arbitration:
  - slot counter runs 0..NUM_VOICES-1 and wraps every cycle, free-running after reset.
  - Cycle t: rom_addr <= note_idx[slot].
  - Cycle t+1: rom_data is captured into div_q[slot_d] and dur_q[slot_d], where slot_d is slot delayed by 1 cycle.
  - Each voice is refreshed every NUM_VOICES cycles.
  - Worst-case latency from index change to new divider on divider_o is NUM_VOICES+1 cycles.
  - Correct note durations require tempo_div >= NUM_VOICES+1; smaller values are legal but the first note length may use stale dur_q.
- divider_o[i] = div_q[i] when PLAY, else 0 (WAIT, IDLE and DONE are silent).
- busy = OR over voices of (WAIT or PLAY).
- loop_end=0: a single note repeats (loop_en=1) or the voice goes to DONE after one note (loop_en=0).
- Widths:
  - note_idx wraps only via loop_end; it never overflows past loop_end.
  - hold is 2 bits wide, wcnt is sized for STAGGER*(NUM_VOICES-1).
- rst_n deasserted mid-play: immediate silence; all state is cleared asynchronously.

Test Plan:
- Reset, STAGGER=8, tempo_div=9, ROM returns {dur=0, divider=100+addr}, start → voice0 PLAY at once with divider 100; voice1 PLAY after 8 ticks (80 cycles); voice2 after 160 cycles; dividers silent until then.
- loop_end=3, loop_en=1, dur=0 → voice0 index sequence 0,1,2,3,0, one step per tick; note_strobe pulses once per change.
- loop_en=0, loop_end=2 → after index 2's note ends: voice goes to DONE, divider 0; busy falls once all voices are DONE.
- ROM dur=2 for addr 1 → index 1 holds for 4 ticks (40 cycles at tempo_div=9); other notes hold for 1 tick.
- start and stop asserted in the same cycle mid-play → all voices IDLE, dividers 0, busy 0; a later start alone restarts from index 0.
- rst_n pulsed low for 1 cycle mid-play (asynchronous, not aligned to clk) → outputs 0 immediately; no activity until the next start.

Source files
------------

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
// Runs NUM_VOICES canon voices from one shared note ROM. The ROM port is
// time-multiplexed round-robin: each cycle one voice's note index goes out on
// rom_addr, and the registered ROM answers one cycle later. Each voice keeps
// its own copy of {duration, divider} and steps through the song on tempo
// ticks. Voice i starts STAGGER*i ticks after voice 0.
//
// Ports:
//   clk          project clock
//   rst_n        asynchronous active-low reset
//   start        pulse: (re)start all voices from note index 0
//   stop         pulse: all voices to IDLE (wins over start)
//   loop_en      1 = wrap to index 0 after loop_end, 0 = finish after loop_end
//   tempo_div    tick period minus 1, in clk cycles
//   loop_end     last note index
//   rom_addr     shared ROM address (note index of the voice in the current slot)
//   rom_data     {dur[1:0], divider}, valid one cycle after rom_addr
//   divider_o    voice i in bits [i*DIV_W +: DIV_W]; 0 = silent
//   note_strobe  1-cycle pulse per voice on PLAY entry or note index change
//   busy         any voice waiting or playing
// -----------------------------------------------------------------------------
module voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int IDX_W      = 9,
    parameter int DIV_W      = 11,
    parameter int STAGGER    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop_en,
    input  logic [15:0]                 tempo_div,
    input  logic [IDX_W-1:0]            loop_end,
    output logic [IDX_W-1:0]            rom_addr,
    input  logic [DIV_W+1:0]            rom_data,
    output logic [NUM_VOICES*DIV_W-1:0] divider_o,
    output logic [NUM_VOICES-1:0]       note_strobe,
    output logic                        busy
);

    localparam int SLOT_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int WCNT_MAX = STAGGER * (NUM_VOICES - 1);
    localparam int WCNT_W   = (WCNT_MAX > 1) ? $clog2(WCNT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PLAY,
        ST_DONE
    } voice_state_t;

    logic [15:0]                 tcnt_reg;
    logic [SLOT_W-1:0]           slot_reg;
    logic [SLOT_W-1:0]           slot_d_reg;
    logic                        tick;
    logic [NUM_VOICES-1:0]       active;
    logic [NUM_VOICES*IDX_W-1:0] note_idx_flat;

    assign busy = |active;
    // >= rather than == so a tempo_div lowered mid-count still wraps cleanly.
    assign tick = busy && (tcnt_reg >= tempo_div);

    // Tempo counter: held at 0 while idle so every start begins a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_reg <= '0;
        end else if (!busy || tick) begin
            tcnt_reg <= '0;
        end else begin
            tcnt_reg <= tcnt_reg + 16'd1;
        end
    end

    // Free-running ROM slot; slot_d_reg names the voice whose data is on
    // rom_data this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg   <= '0;
            slot_d_reg <= '0;
        end else begin
            slot_d_reg <= slot_reg;
            if (slot_reg == SLOT_W'(NUM_VOICES - 1)) begin
                slot_reg <= '0;
            end else begin
                slot_reg <= slot_reg + 1'b1;
            end
        end
    end

    // Address mux driven straight from registers, so the registered ROM
    // returns the data exactly when slot_d_reg points at the same voice.
    always_comb begin
        rom_addr = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (slot_reg == SLOT_W'(v)) begin
                rom_addr = note_idx_flat[v*IDX_W +: IDX_W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            localparam int WAIT_INIT = STAGGER * gi;

            voice_state_t      state_reg;
            logic [IDX_W-1:0]  note_idx_reg;
            logic [DIV_W-1:0]  div_q_reg;
            logic [1:0]        dur_q_reg;
            logic [1:0]        hold_reg;
            logic [1:0]        hold_last;
            logic [WCNT_W-1:0] wcnt_reg;
            logic              strobe_reg;

            // Last hold value of a note: 2^dur ticks long. dur=3 would need
            // eight ticks, which a 2-bit hold counter cannot reach, so it
            // saturates at four ticks instead of hanging the voice.
            always_comb begin
                case (dur_q_reg)
                    2'd0:    hold_last = 2'd0;
                    2'd1:    hold_last = 2'd1;
                    default: hold_last = 2'd3;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg    <= ST_IDLE;
                    note_idx_reg <= '0;
                    div_q_reg    <= '0;
                    dur_q_reg    <= '0;
                    hold_reg     <= '0;
                    wcnt_reg     <= '0;
                    strobe_reg   <= 1'b0;
                end else begin
                    strobe_reg <= 1'b0;

                    // Refresh this voice's note data whenever its slot returns,
                    // regardless of state, so it is current on PLAY entry.
                    if (slot_d_reg == SLOT_W'(gi)) begin
                        div_q_reg <= rom_data[DIV_W-1:0];
                        dur_q_reg <= rom_data[DIV_W+1:DIV_W];
                    end

                    if (stop) begin
                        state_reg <= ST_IDLE;
                    end else if (start) begin
                        note_idx_reg <= '0;
                        hold_reg     <= '0;
                        if (WAIT_INIT == 0) begin
                            state_reg  <= ST_PLAY;
                            strobe_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_WAIT;
                            wcnt_reg  <= WCNT_W'(WAIT_INIT);
                        end
                    end else if (tick) begin
                        case (state_reg)
                            ST_WAIT: begin
                                if (wcnt_reg == WCNT_W'(1)) begin
                                    state_reg  <= ST_PLAY;
                                    strobe_reg <= 1'b1;
                                end else begin
                                    wcnt_reg <= wcnt_reg - 1'b1;
                                end
                            end
                            ST_PLAY: begin
                                if (hold_reg == hold_last) begin
                                    hold_reg <= '0;
                                    if (note_idx_reg != loop_end) begin
                                        note_idx_reg <= note_idx_reg + 1'b1;
                                        strobe_reg   <= 1'b1;
                                    end else if (loop_en) begin
                                        note_idx_reg <= '0;
                                        strobe_reg   <= 1'b1;
                                    end else begin
                                        state_reg <= ST_DONE;
                                    end
                                end else begin
                                    hold_reg <= hold_reg + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            assign note_idx_flat[gi*IDX_W +: IDX_W] = note_idx_reg;
            assign divider_o[gi*DIV_W +: DIV_W]     = (state_reg == ST_PLAY) ? div_q_reg : '0;
            assign note_strobe[gi]                  = strobe_reg;
            assign active[gi]                       = (state_reg == ST_WAIT) || (state_reg == ST_PLAY);
        end
    endgenerate

endmodule
